// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
// Module      : mux4_rr_arbiter_pkg
// Description : Shared constants for the 4-way round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux4_rr_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    // Starting from 3 makes requester 0 the first to be searched after reset.
    localparam logic [IDX_W-1:0] LAST_IDX_RST = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_pick.sv
// ============================================================================
// Module      : rr_pick4
// Description : Rotated-priority search: first set req bit after last_idx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] w_cand;

    // Walk from farthest to nearest so the nearest set bit is written last;
    // k == NUM_REQ wraps to last_idx itself, which is searched last.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = last_idx + IDX_W'(k);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter with hold limit driving a mux_4x1 select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               s0,
    output logic               s1,
    output logic               valid
);

    localparam logic [CNT_W-1:0]   c_hold_last = CNT_W'(MAX_HOLD - 1);
    localparam logic [NUM_REQ-1:0] c_one       = NUM_REQ'(1);

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_sel;
    logic               r_valid;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [IDX_W-1:0]   r_last_idx;

    logic [IDX_W-1:0]   w_search_base;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_release;

    // While granted, the search rotates from the current holder so a
    // released or timed-out holder is considered last.
    assign w_search_base = (r_state == ST_GRANT) ? r_sel : r_last_idx;
    assign w_release     = ~req[r_sel] | (r_hold_cnt == c_hold_last);

    rr_pick4 u_pick (
        .req      (req),
        .last_idx (w_search_base),
        .found    (w_found),
        .idx      (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_valid    <= 1'b0;
            r_hold_cnt <= '0;
            r_last_idx <= LAST_IDX_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_GRANT;
                        r_gnt      <= c_one << w_pick_idx;
                        r_sel      <= w_pick_idx;
                        r_valid    <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_last_idx <= r_sel;
                        if (w_found) begin
                            r_gnt      <= c_one << w_pick_idx;
                            r_sel      <= w_pick_idx;
                            r_hold_cnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                            r_valid <= 1'b0;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign s0    = r_sel[0];
    assign s1    = r_sel[1];
    assign valid = r_valid;

endmodule

`default_nettype wire
